// File: rtl/memory_port_arbiter.sv
// Arbitrates one single-port word memory between instruction fetch and data access.
// Data wins by default; a streak counter hands the port to fetch after STARVE_LIMIT data wins.
module memory_port_arbiter #(
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [3:0] LAT_M1   = 4'(LATENCY - 1);
  localparam logic [3:0] STARVE_W = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] streak;
  logic       gnt_d;
  logic       lat_we;
  logic       if_elig, d_elig;
  logic       grant_if, grant_d;
  logic       done;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_W) ? STARVE_W : v + 4'd1;
  endfunction

  // A requester whose ready pulses this cycle is still holding its old req,
  // so it is masked out to avoid granting the same access twice.
  always_comb begin
    if_elig   = if_req && !if_ready;
    d_elig    = d_req && !d_ready;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    state_nxt = state;
    done      = (state == ACCESS) && (cnt == 4'd0);
    case (state)
      IDLE: begin
        if (if_elig && (!d_elig || streak == STARVE_W)) grant_if = 1'b1;
        else if (d_elig)                                 grant_d  = 1'b1;
        if (grant_if || grant_d) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (cnt == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      streak    <= 4'd0;
      gnt_d     <= 1'b0;
      lat_we    <= 1'b0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state    <= state_nxt;
      if_ready <= done && !gnt_d;
      d_ready  <= done && gnt_d;
      if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (grant_if) begin
        gnt_d    <= 1'b0;
        lat_we   <= 1'b0;
        mem_addr <= if_addr;
        cnt      <= LAT_M1;
        streak   <= 4'd0;
      end
      if (grant_d) begin
        gnt_d     <= 1'b1;
        lat_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        cnt       <= LAT_M1;
        streak    <= if_req ? sat_inc(streak) : 4'd0;
      end
      // Read data is captured before the write edge, so writes return the old word.
      if (done) begin
        if (gnt_d) d_rdata  <= mem_rdata;
        else       if_rdata <= mem_rdata;
      end
    end
  end

  assign mem_we = done && lat_we;
  assign busy   = (state == ACCESS);

endmodule
